weight_stream_reader: RTL and testbench

- Sequential reader that sits directly downstream of the weight memory block.
- On a start command it walks a contiguous address range, drives the memory read address, and captures the 1-cycle-latency read data.
- It emits the words as an AXI-Stream packet toward the router, with full backpressure support and one beat per cycle sustained throughput.

---
 rtl/weight_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_weight_stream_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_reader.sv
// Streams a contiguous, wrapping address range out of the weight memory as one
// AXI-Stream packet, with a 2-entry skid FIFO absorbing the 1-cycle read latency.
module weight_stream_reader #(
  parameter int DATAW = 128,
  parameter int DEPTH = 64,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int DESTW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   len,
  input  logic [DESTW-1:0] dest,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DATAW-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic [DESTW-1:0] m_axis_tdest
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [ADDRW-1:0] next_addr;
  logic [ADDRW-1:0] raddr_q;
  logic [ADDRW:0]   len_q;
  logic [ADDRW:0]   issue_cnt;
  logic [DESTW-1:0] dest_q;
  logic             inflight;
  logic             inflight_last;
  logic             done_q;

  logic [DATAW-1:0] fifo_data [2];
  logic [1:0]       fifo_last;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_cnt;

  logic             accept;
  logic             issue;
  logic             issue_last;
  logic [ADDRW-1:0] issue_addr;
  logic [ADDRW:0]   issue_cnt_next;
  logic [2:0]       occupancy;
  logic             pop;
  logic             fifo_wr;
  logic             last_beat;

  function automatic logic [ADDRW-1:0] addr_inc(input logic [ADDRW-1:0] a);
    return (a == ADDRW'(DEPTH - 1)) ? '0 : a + ADDRW'(1);
  endfunction

  assign pop           = m_axis_tvalid && m_axis_tready;
  assign fifo_wr       = inflight;
  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];
  assign m_axis_tdest  = dest_q;
  assign last_beat     = pop && m_axis_tlast;
  assign busy          = (state != IDLE);
  assign done          = done_q;

  // The first read goes out in the start cycle itself, so the address path
  // bypasses the register; otherwise the last issued address is held.
  assign mem_raddr = issue ? issue_addr : raddr_q;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    issue          = 1'b0;
    issue_addr     = next_addr;
    issue_cnt_next = issue_cnt + (ADDRW+1)'(1);
    issue_last     = (issue_cnt_next == len_q);
    occupancy      = {1'b0, fifo_cnt} + {2'b0, inflight};

    case (state)
      IDLE: begin
        if (start && len != '0) begin
          accept         = 1'b1;
          issue          = 1'b1;
          issue_addr     = base_addr;
          issue_cnt_next = (ADDRW+1)'(1);
          issue_last     = (len == (ADDRW+1)'(1));
          state_next     = issue_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        // Never let buffered + in-flight words exceed the two FIFO slots.
        if (occupancy < 3'd2 + {2'b0, pop}) begin
          issue = 1'b1;
          if (issue_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (rst) begin
      accept = 1'b0;
      issue  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q       <= '0;
      next_addr     <= '0;
      len_q         <= '0;
      issue_cnt     <= '0;
      dest_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= (state == DRAIN) && last_beat;
      inflight      <= issue;
      inflight_last <= issue && issue_last;
      if (accept) begin
        len_q  <= len;
        dest_q <= dest;
      end
      if (issue) begin
        raddr_q   <= issue_addr;
        next_addr <= addr_inc(issue_addr);
        issue_cnt <= issue_cnt_next;
      end
      if (fifo_wr) begin
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, fifo_wr} - {1'b0, pop};
    end
  end

  // NOTE: the data storage is deliberately not reset; fifo_cnt alone says
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_data[wr_ptr] <= mem_rdata;
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !pop && fifo_cnt == 2'd2));

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader: a registered memory model with
// word i = i, a beat monitor, and a table of packet commands.
module tb_weight_stream_reader;

  localparam int DATAW = 128;
  localparam int DEPTH = 64;
  localparam int ADDRW = 6;
  localparam int DESTW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [ADDRW:0]   len;
  logic [DESTW-1:0] dest;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] mem_raddr;
  logic [DATAW-1:0] mem_rdata;
  logic             tvalid;
  logic             tready;
  logic [DATAW-1:0] tdata;
  logic             tlast;
  logic [DESTW-1:0] tdest;

  weight_stream_reader #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .DESTW(DESTW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .dest(dest), .busy(busy), .done(done), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tdest(tdest)
  );

  always #5 clk = ~clk;

  logic [DATAW-1:0] mem [DEPTH];
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [DATAW-1:0] data;
    logic             last;
    logic [DESTW-1:0] dest;
    int               cyc;
  } beat_t;

  beat_t beats[$];
  int    done_cnt = 0;
  int    done_cyc = 0;

  // Monitor: records handshakes and done pulses, checks hold-during-stall.
  logic         prev_stall = 1'b0;
  logic [133:0] prev_word;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {tvalid, tlast, tdest, tdata}, prev_word);
      if (tvalid && tready) beats.push_back('{tdata, tlast, tdest, cyc});
      prev_stall = tvalid && !tready;
      prev_word  = {tvalid, tlast, tdest, tdata};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int base;
    int len;
    int dest;
    bit bp;        // pseudo-random tready instead of constant 1
    bit intrude;   // extra start pulse while busy
    bit b2b;       // start in the done cycle of the previous packet
    int exp_beats;
    int exp_first;
    int exp_lastword;
  } vec_t;

  logic [15:0] pat = 16'b0110_1001_1001_1010;

  task automatic start_cmd(input int b, input int l, input int d);
    start     = 1'b1;
    base_addr = ADDRW'(b);
    len       = (ADDRW+1)'(l);
    dest      = DESTW'(d);
  endtask

  task automatic run_vec(input vec_t v, input bit chain);
    int s;
    bit seen;
    beats.delete();
    done_cnt = 0;
    if (!v.b2b) @(negedge clk);
    start_cmd(v.base, v.len, v.dest);
    tready = 1'b1;
    s = cyc;
    #1;
    if (!v.bp) check("raddr_first", mem_raddr, v.base);
    seen = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (v.intrude && k == 2) start_cmd(40, 3, 1);
      else start = 1'b0;
      tready = v.bp ? pat[k % 16] : 1'b1;
      #3;
      if (k == 1) check("busy_run", busy, 1);
      if (!v.bp && k < v.len) check("raddr_seq", mem_raddr, (v.base + k) % DEPTH);
      if (done_cnt != 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("busy_at_done", busy, 0);
    check("beat_count", beats.size(), v.exp_beats);
    if (beats.size() > 0) begin
      check("first_word", beats[0].data, v.exp_first);
      check("last_word", beats[beats.size()-1].data, v.exp_lastword);
    end
    foreach (beats[i]) begin
      check("beat_data", beats[i].data, (v.base + i) % DEPTH);
      check("beat_last", beats[i].last, (i == v.len - 1));
      check("beat_dest", beats[i].dest, v.dest);
    end
    if (!v.bp && seen && beats.size() > 0) begin
      check("first_valid_cycle", beats[0].cyc, s + 2);
      check("done_cycle", done_cyc, s + v.len + 2);
    end
    if (!chain) begin
      repeat (3) @(negedge clk);
      #3;
      check("done_once", done_cnt, 1);
    end
  endtask

  vec_t vecs[8];
  int   s;

  initial begin
    vecs[0] = '{0,  4,  3, 0, 0, 0, 4,  0,  3};
    vecs[1] = '{62, 4,  5, 0, 0, 0, 4,  62, 1};
    vecs[2] = '{60, 8,  7, 1, 0, 0, 8,  60, 3};
    vecs[3] = '{0,  64, 1, 0, 0, 0, 64, 0,  63};
    vecs[4] = '{10, 1,  2, 0, 0, 0, 1,  10, 10};
    vecs[5] = '{20, 6,  9, 0, 1, 0, 6,  20, 25};
    vecs[6] = '{33, 3,  6, 0, 0, 1, 3,  33, 35};
    vecs[7] = '{50, 5, 11, 1, 0, 0, 5,  50, 54};

    for (int i = 0; i < DEPTH; i++) mem[i] = DATAW'(i);

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; dest = '0; tready = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tlast", tlast, 0);
    check("rst_raddr", mem_raddr, 0);
    @(negedge clk);
    rst = 1'b0;

    // len == 0 is ignored entirely.
    done_cnt = 0;
    @(negedge clk);
    start_cmd(5, 0, 2);
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      #3;
      check("len0_busy", busy, 0);
      check("len0_tvalid", tvalid, 0);
    end
    check("len0_done", done_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      bit chain;
      chain = (i < 7) ? vecs[i+1].b2b : 1'b0;
      run_vec(vecs[i], chain);
    end

    // Reset during beat 3 of an 8-word packet.
    beats.delete();
    done_cnt = 0;
    @(negedge clk);
    start_cmd(0, 8, 4);
    tready = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("mid_cycle", cyc, s + 4);
    check("mid_beat3_valid", tvalid, 1);
    check("mid_beat3_data", tdata, 2);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("mid_no_done", done_cnt, 0);
    check("mid_idle_tvalid", tvalid, 0);
    run_vec('{5, 2, 8, 0, 0, 0, 2, 5, 6}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
